// File: rtl/ps2_host_tx_if.sv
// Signal bundle between a PS/2 host transmitter (slave side) and the logic
// that requests transfers and owns the open-drain pads (master side).
interface ps2_host_tx_if;
  logic       start;
  logic [7:0] data_in;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, data_in, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, busy, done, err
  );

  modport slave (
    input  start, data_in, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks one command byte
// out under device-generated clocking and reports the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic          clk,
  input logic          resetn,
  ps2_host_tx_if.slave bus
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic             c_meta, c_sync, c_prev;
  logic             d_meta, d_sync;
  logic             fall;
  logic [INH_W-1:0] inh_cnt, inh_cnt_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [9:0]       frame, frame_next;
  logic             c_oe, c_oe_next;
  logic             d_oe, d_oe_next;
  logic             busy_q, busy_next;
  logic             done_q, done_next;
  logic             err_q, err_next;
  logic             in_transfer;

  // Synchronizers idle high so leaving reset never looks like a clock fall.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      c_prev <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= bus.ps2c_in;
      c_sync <= c_meta;
      c_prev <= c_sync;
      d_meta <= bus.ps2d_in;
      d_sync <= d_meta;
    end
  end

  assign fall        = c_prev & ~c_sync;
  assign in_transfer = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      inh_cnt <= '0;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      frame   <= '0;
      c_oe    <= 1'b0;
      d_oe    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      inh_cnt <= inh_cnt_next;
      tmo_cnt <= tmo_cnt_next;
      bit_cnt <= bit_cnt_next;
      frame   <= frame_next;
      c_oe    <= c_oe_next;
      d_oe    <= d_oe_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
      err_q   <= err_next;
    end
  end

  // Outputs are registered from the next state so the pads never glitch.
  always_comb begin
    state_next   = state;
    inh_cnt_next = inh_cnt;
    tmo_cnt_next = tmo_cnt;
    bit_cnt_next = bit_cnt;
    frame_next   = frame;
    d_oe_next    = d_oe;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        d_oe_next = 1'b0;
        if (bus.start) begin
          frame_next   = {1'b1, ~^bus.data_in, bus.data_in};
          inh_cnt_next = '0;
          tmo_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_next = inh_cnt + 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_next = REQ;
          d_oe_next  = 1'b1;
        end
      end
      REQ: begin
        tmo_cnt_next = '0;
        state_next   = SHIFT;
      end
      SHIFT: begin
        tmo_cnt_next = tmo_cnt + 1'b1;
        if (fall) begin
          d_oe_next    = ~frame[0];
          frame_next   = {1'b0, frame[9:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == 4'd9) state_next = ACK;
        end
      end
      ACK: begin
        tmo_cnt_next = tmo_cnt + 1'b1;
        if (fall) begin
          if (!d_sync) begin
            state_next = WAIT_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        tmo_cnt_next = tmo_cnt + 1'b1;
        if (c_sync && d_sync) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A stalled device wins over any protocol progress in the same cycle.
    if (in_transfer && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_next = IDLE;
      d_oe_next  = 1'b0;
      done_next  = 1'b0;
      err_next   = 1'b1;
    end

    c_oe_next = (state_next == INHIBIT) || (state_next == REQ);
    busy_next = (state_next != IDLE);
  end

  assign bus.ps2c_oe = c_oe;
  assign bus.ps2d_oe = d_oe;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple PS/2
// device model that clocks the frame, samples data and optionally acks.
module tb_ps2_host_tx;
  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 15;

  logic clk       = 1'b0;
  logic resetn    = 1'b0;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  logic glitch_en = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  int   done_total = 0, err_total = 0, both_total = 0;
  int   inh_total  = 0, req_total = 0;
  int   chg_total  = 0, viol_total = 0;
  int   since_fall = 100;
  logic prev_dev_c = 1'b0;
  logic prev_d_oe  = 1'b0;

  ps2_host_tx_if bus_if ();

  assign bus_if.ps2c_in = ~(bus_if.ps2c_oe | dev_c_low);
  assign bus_if.ps2d_in = ~(bus_if.ps2d_oe | dev_d_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_if)
  );

  always #10 clk = ~clk;

  // Pulse/phase counters sampled just after each rising edge; the data-drive
  // rule expects a change two edges after the first edge that sees the fall.
  always @(posedge clk) begin
    #1;
    if (dev_c_low && !prev_dev_c) since_fall = 0;
    else                          since_fall = since_fall + 1;
    prev_dev_c = dev_c_low;
    if (glitch_en && !bus_if.ps2c_oe && (bus_if.ps2d_oe !== prev_d_oe)) begin
      chg_total = chg_total + 1;
      if (since_fall != 2) viol_total = viol_total + 1;
    end
    prev_d_oe = bus_if.ps2d_oe;
    if (bus_if.done) done_total = done_total + 1;
    if (bus_if.err) err_total = err_total + 1;
    if (bus_if.done && bus_if.err) both_total = both_total + 1;
    if (bus_if.ps2c_oe && !bus_if.ps2d_oe) inh_total = inh_total + 1;
    if (bus_if.ps2c_oe && bus_if.ps2d_oe) req_total = req_total + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.data_in = b;
    @(negedge clk);
    bus_if.start   = 1'b0;
  endtask

  // Returns on the first cycle with the clock released and the start bit low.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INHIBIT + 20; i++) begin
      @(negedge clk);
      if (!bus_if.ps2c_oe && bus_if.ps2d_oe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic dev_clocks(input int n, output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[i]   = bus_if.ps2d_in;
      dev_c_low = 1'b0;
    end
  endtask

  task automatic dev_ack(input bit give_ack);
    repeat (7) @(negedge clk);
    dev_d_low = give_ack;
    repeat (8) @(negedge clk);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_d_low = 1'b0;
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus_if.busy) break;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit give_ack,
                           output logic [9:0] bits);
    bit ok;
    apply_stimulus(b);
    check_output("busy after start", 32'(bus_if.busy), 1);
    wait_req(ok);
    check_output("request reached", 32'(ok), 1);
    check_output("start bit low", 32'(bus_if.ps2d_in), 0);
    dev_clocks(10, bits);
    dev_ack(give_ack);
    wait_not_busy();
  endtask

  initial begin
    logic [9:0] bits;
    int         d0, e0, i0, r0, n;
    bit         ok;

    bus_if.start   = 1'b0;
    bus_if.data_in = 8'h00;
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    check_output("reset ps2c_oe", 32'(bus_if.ps2c_oe), 0);
    check_output("reset ps2d_oe", 32'(bus_if.ps2d_oe), 0);
    check_output("reset busy", 32'(bus_if.busy), 0);
    check_output("reset done", 32'(bus_if.done), 0);
    check_output("reset err", 32'(bus_if.err), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] send 0xED with ack");
    d0 = done_total; e0 = err_total; i0 = inh_total; r0 = req_total;
    glitch_en = 1'b1;
    send_byte(8'hED, 1'b1, bits);
    glitch_en = 1'b0;
    check_output("ED frame", 32'(bits), 32'h3ED);
    check_output("ED inhibit length", 32'(inh_total - i0), INHIBIT);
    check_output("ED request length", 32'(req_total - r0), 1);
    check_output("ED done pulses", 32'(done_total - d0), 1);
    check_output("ED err pulses", 32'(err_total - e0), 0);
    check_output("ED busy end", 32'(bus_if.busy), 0);
    check_output("ED lines released", 32'({bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);
    check_output("ED data changes", 32'(chg_total), 5);
    check_output("ED off-fall changes", 32'(viol_total), 0);

    $display("[TB] parity corner bytes");
    d0 = done_total;
    send_byte(8'h00, 1'b1, bits);
    check_output("00 frame", 32'(bits), 32'h300);
    send_byte(8'hFF, 1'b1, bits);
    check_output("FF frame", 32'(bits), 32'h3FF);
    send_byte(8'h01, 1'b1, bits);
    check_output("01 frame", 32'(bits), 32'h201);
    check_output("corner done pulses", 32'(done_total - d0), 3);

    $display("[TB] device withholds ack");
    d0 = done_total; e0 = err_total;
    send_byte(8'h5A, 1'b0, bits);
    check_output("5A frame", 32'(bits), 32'h35A);
    check_output("noack err pulses", 32'(err_total - e0), 1);
    check_output("noack done pulses", 32'(done_total - d0), 0);
    check_output("noack lines released", 32'({bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);
    check_output("noack busy", 32'(bus_if.busy), 0);

    $display("[TB] device never clocks");
    d0 = done_total;
    apply_stimulus(8'h33);
    wait_req(ok);
    check_output("timeout request reached", 32'(ok), 1);
    n = 0;
    for (int i = 0; i < TIMEOUT + 50; i++) begin
      @(negedge clk);
      n = n + 1;
      if (bus_if.err) break;
    end
    check_output("timeout latency", 32'(n), TIMEOUT);
    check_output("timeout lines released", 32'({bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);
    check_output("timeout no done", 32'(done_total - d0), 0);
    wait_not_busy();
    check_output("timeout busy", 32'(bus_if.busy), 0);

    $display("[TB] restart ignored, then reset mid-frame");
    i0 = inh_total;
    apply_stimulus(8'hA5);
    repeat (100) @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.data_in = 8'h3C;
    @(negedge clk);
    bus_if.start   = 1'b0;
    check_output("restart busy", 32'(bus_if.busy), 1);
    check_output("restart still inhibiting", 32'({bus_if.ps2c_oe, bus_if.ps2d_oe}), 2);
    wait_req(ok);
    check_output("abort request reached", 32'(ok), 1);
    check_output("abort inhibit length", 32'(inh_total - i0), INHIBIT);
    dev_clocks(4, bits);
    check_output("abort first bits", 32'(bits[3:0]), 32'h5);
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b1;
    repeat (6) @(negedge clk);
    d0 = done_total; e0 = err_total;
    resetn = 1'b0;
    @(negedge clk);
    check_output("abort lines released", 32'({bus_if.ps2c_oe, bus_if.ps2d_oe}), 0);
    check_output("abort busy", 32'(bus_if.busy), 0);
    resetn    = 1'b1;
    dev_c_low = 1'b0;
    repeat (200) @(negedge clk);
    check_output("abort no done", 32'(done_total - d0), 0);
    check_output("abort no err", 32'(err_total - e0), 0);
    check_output("abort idle busy", 32'(bus_if.busy), 0);
    check_output("done with err ever", 32'(both_total), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
